// File: rtl/game_pkg.sv
// Shared game encodings and default playfield geometry.
// Used by the player controller and the enemy movers.
package game_pkg;

  localparam int GAME_W = 640;
  localparam int GAME_H = 480;
  localparam int GRID_W = 16;
  localparam int GRID_H = 16;

  typedef enum logic [1:0] {
    GS_MENU  = 2'b00,
    GS_RUN   = 2'b01,
    GS_PAUSE = 2'b10,
    GS_CLEAN = 2'b11
  } game_state_e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_RESPAWN = 2'b01,
    ST_LEVELUP = 2'b10,
    ST_OVER    = 2'b11
  } ply_state_e;

endpackage

// File: rtl/move_tick_gen.sv
// Free-running clock-enable: o_Tick is high for one cycle
// every TICK_DIV cycles, on the last count before the wrap.
module move_tick_gen #(
  parameter int TICK_DIV = 2000000
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  output logic o_Tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign o_Tick = (cnt == LAST);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt <= '0;
    end else if (o_Tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/player_grid_ctrl.sv
// Grid-stepping player controller: position, level, lives, FSM.
// MOVE_REPEAT_EN: held buttons step every tick (else one step per press).
module player_grid_ctrl
  import game_pkg::*;
#(
  parameter int COORD_W   = 10,
  parameter int GAME_W    = game_pkg::GAME_W,
  parameter int GAME_H    = game_pkg::GAME_H,
  parameter int GRID_W    = game_pkg::GRID_W,
  parameter int GRID_H    = game_pkg::GRID_H,
  parameter int PLAYER_W  = 16,
  parameter int PLAYER_H  = 16,
  parameter int TICK_DIV  = 2000000,
  parameter int MAX_LEVEL = 9,
  parameter int LIVES     = 3
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_Up,
  input  logic               i_Dn,
  input  logic               i_Lt,
  input  logic               i_Rt,
  input  logic               i_Collision,
  input  logic [1:0]         i_Game_State,
  input  logic               i_Reset_Level,
  output logic [COORD_W-1:0] o_Player_X,
  output logic [COORD_W-1:0] o_Player_Y,
  output logic [3:0]         o_Level,
  output logic [2:0]         o_Lives,
  output logic               o_Level_Up,
  output logic               o_Died,
  output logic               o_Game_Over
);

  localparam logic [COORD_W-1:0] X_MAX =
    COORD_W'(GAME_W - PLAYER_W);
  localparam logic [COORD_W-1:0] Y_MAX =
    COORD_W'(GAME_H - PLAYER_H);
  localparam logic [COORD_W-1:0] GX = COORD_W'(GRID_W);
  localparam logic [COORD_W-1:0] GY = COORD_W'(GRID_H);
  localparam logic [COORD_W-1:0] SPAWN_X =
    COORD_W'((GAME_W / 2) / GRID_W * GRID_W);
  localparam logic [COORD_W-1:0] SPAWN_Y =
    COORD_W'((GAME_H - PLAYER_H) / GRID_H * GRID_H);
  localparam logic [3:0] LVL_MAX = 4'(MAX_LEVEL);
  localparam logic [2:0] LIVES_INIT = 3'(LIVES);

  ply_state_e state, nxt;
  logic [COORD_W-1:0] x, y;
  logic [3:0] level;
  logic [2:0] lives;
  logic tick, run_ok, move_ok;
  logic req_up, req_dn, req_lt, req_rt;

  move_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .o_Tick  (tick)
  );

  assign run_ok  = (state == ST_RUN) && (i_Game_State == GS_RUN);
  assign move_ok = run_ok && tick && !i_Collision;

`ifdef MOVE_REPEAT_EN
  assign req_up = i_Up;
  assign req_dn = i_Dn;
  assign req_lt = i_Lt;
  assign req_rt = i_Rt;
`else
  logic [3:0] btn, btn_q, arm;

  assign btn = {i_Up, i_Dn, i_Lt, i_Rt};
  assign {req_up, req_dn, req_lt, req_rt} = arm;

  // A rising edge arms one step; the next move tick consumes it.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      btn_q <= '0;
      arm   <= '0;
    end else begin
      btn_q <= btn;
      if (!run_ok) begin
        arm <= '0;
      end else begin
        arm <= (arm & {4{!move_ok}}) | (btn & ~btn_q);
      end
    end
  end
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    if (i_Reset_Level) begin
      nxt = ST_RUN;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (i_Game_State == GS_RUN) begin
            if (i_Collision) begin
              nxt = ST_RESPAWN;
            end else if (y == '0) begin
              nxt = ST_LEVELUP;
            end
          end
        end
        ST_RESPAWN: nxt = (lives <= 3'd1) ? ST_OVER : ST_RUN;
        ST_LEVELUP: nxt = ST_RUN;
        ST_OVER:    nxt = ST_OVER;
        default:    nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      x     <= SPAWN_X;
      y     <= SPAWN_Y;
      level <= 4'd1;
      lives <= LIVES_INIT;
    end else if (i_Reset_Level) begin
      x     <= SPAWN_X;
      y     <= SPAWN_Y;
      level <= 4'd1;
      lives <= LIVES_INIT;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (i_Game_State == GS_CLEAN) begin
            x <= SPAWN_X;
            y <= SPAWN_Y;
          end else if (move_ok) begin
            // Clamp against the edges so nothing wraps.
            if (req_up) begin
              if (y != '0) y <= (y >= GY) ? y - GY : '0;
            end else if (req_dn) begin
              if (y < Y_MAX)
                y <= (Y_MAX - y >= GY) ? y + GY : Y_MAX;
            end
            if (req_lt) begin
              if (x != '0) x <= (x >= GX) ? x - GX : '0;
            end else if (req_rt) begin
              if (x < X_MAX)
                x <= (X_MAX - x >= GX) ? x + GX : X_MAX;
            end
          end
        end
        ST_RESPAWN: begin
          x <= SPAWN_X;
          y <= SPAWN_Y;
          if (lives != 3'd0) lives <= lives - 3'd1;
        end
        ST_LEVELUP: begin
          x <= SPAWN_X;
          y <= SPAWN_Y;
          if (level < LVL_MAX) level <= level + 4'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_Player_X  = x;
  assign o_Player_Y  = y;
  assign o_Level     = level;
  assign o_Lives     = lives;
  assign o_Level_Up  = (state == ST_LEVELUP);
  assign o_Died      = (state == ST_RESPAWN);
  assign o_Game_Over = (state == ST_OVER);

endmodule

// File: tb/tb_player_grid_ctrl.sv
// Directed bench for player_grid_ctrl, default build
// (one step per press), TICK_DIV=4 on a 64x64 field.
module tb_player_grid_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       up = 0, dn = 0, lt = 0, rt = 0;
  logic       coll = 0;
  logic [1:0] gs = 2'b01;
  logic       rlvl = 0;
  logic [9:0] px, py;
  logic [3:0] lvl;
  logic [2:0] lives;
  logic       lvl_up, died, over;

  int checks = 0;
  int failures = 0;
  int ecnt = 0;

  player_grid_ctrl #(
    .COORD_W(10), .GAME_W(64), .GAME_H(64),
    .GRID_W(16), .GRID_H(16),
    .PLAYER_W(16), .PLAYER_H(16),
    .TICK_DIV(4), .MAX_LEVEL(9), .LIVES(3)
  ) dut (
    .i_Clk         (clk),
    .i_Rst_n       (rst_n),
    .i_Up          (up),
    .i_Dn          (dn),
    .i_Lt          (lt),
    .i_Rt          (rt),
    .i_Collision   (coll),
    .i_Game_State  (gs),
    .i_Reset_Level (rlvl),
    .o_Player_X    (px),
    .o_Player_Y    (py),
    .o_Level       (lvl),
    .o_Lives       (lives),
    .o_Level_Up    (lvl_up),
    .o_Died        (died),
    .o_Game_Over   (over)
  );

  always #5 clk = ~clk;

  // Bench-side edge count since reset release; ticks land on ecnt%4==0.
  always @(posedge clk) if (rst_n) ecnt <= ecnt + 1;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic align();
    while (ecnt % 4 != 0) cyc(1);
  endtask

  // Press for one cycle, return just after the tick edge that consumes it.
  task automatic press_step(input logic u, input logic d,
                            input logic l, input logic r);
    align();
    {up, dn, lt, rt} = {u, d, l, r};
    cyc(1);
    {up, dn, lt, rt} = 4'b0000;
    cyc(3);
  endtask

  task automatic climb();
    repeat (3) press_step(1, 0, 0, 0);
    cyc(2);
  endtask

  task automatic hit();
    coll = 1;
    cyc(1);
    chk("died_pulse", died, 1);
    coll = 0;
    cyc(1);
    chk("died_clear", died, 0);
  endtask

  initial begin
    cyc(3);
    rst_n = 1;
    chk("rst_x", px, 32);
    chk("rst_y", py, 48);
    chk("rst_lvl", lvl, 1);
    chk("rst_lives", lives, 3);
    chk("rst_pulses", {lvl_up, died, over}, 0);

    for (int i = 0; i < 8; i++) begin
      chk("tick", dut.tick, (ecnt % 4 == 3) ? 1 : 0);
      cyc(1);
    end

    press_step(1, 0, 0, 1);
    chk("ur1_y", py, 32);
    chk("ur1_x", px, 48);
    press_step(1, 0, 0, 1);
    chk("ur2_y", py, 16);
    chk("ur2_x_cap", px, 48);
    press_step(1, 0, 0, 1);
    chk("ur3_y", py, 0);
    chk("ur3_x_cap", px, 48);
    cyc(1);
    chk("lvlup_pulse", lvl_up, 1);
    cyc(1);
    chk("lvlup_clear", lvl_up, 0);
    chk("lvl2", lvl, 2);
    chk("lvlup_spawn_y", py, 48);
    chk("lvlup_spawn_x", px, 32);

    press_step(1, 1, 1, 1);
    chk("both_y", py, 32);
    chk("both_x", px, 16);
    press_step(0, 0, 1, 0);
    chk("lt_x0", px, 0);
    press_step(0, 0, 1, 0);
    chk("lt_x0_hold", px, 0);

    align();
    up = 1;
    cyc(20);
    up = 0;
    chk("held_one_step", py, 16);

    gs = 2'b10;
    press_step(1, 0, 0, 0);
    chk("pause_y", py, 16);
    chk("pause_lvl", lvl, 2);
    gs = 2'b01;

    hit();
    chk("lives2", lives, 2);
    chk("respawn_y", py, 48);
    chk("respawn_x", px, 32);
    hit();
    chk("lives1", lives, 1);
    chk("not_over", over, 0);
    hit();
    chk("lives0", lives, 0);
    chk("over", over, 1);
    press_step(1, 0, 0, 0);
    chk("over_frozen_y", py, 48);
    chk("over_stays", over, 1);

    rlvl = 1;
    cyc(1);
    rlvl = 0;
    chk("rl_lives", lives, 3);
    chk("rl_lvl", lvl, 1);
    chk("rl_over", over, 0);
    chk("rl_y", py, 48);

    repeat (8) climb();
    chk("lvl9", lvl, 9);
    repeat (3) press_step(1, 0, 0, 0);
    chk("max_goal_y", py, 0);
    cyc(1);
    chk("max_lvlup_pulse", lvl_up, 1);
    cyc(1);
    chk("max_lvl_sat", lvl, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
